// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EX/MEM and MEM/WB registers, a 256x16 data memory and a retire counter.
// Define DMEM_MISALIGN_TRAP_EN to trap odd-address loads/stores (sticky fault + first fault address).
module mem_wb_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_store_data,
    input  logic [1:0]  ex_wr,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_memwrite,
    output logic [15:0] wb_wd,
    output logic [1:0]  wb_wr,
    output logic        wb_regwrite,
    output logic [1:0]  exmem_wr,
    output logic        exmem_regwrite,
    output logic [15:0] exmem_alu_out,
    output logic        fault,
    output logic [15:0] fault_addr,
    output logic [15:0] retired
);

    logic        exmem_valid_q, exmem_valid_d;
    logic [15:0] exmem_alu_q, exmem_alu_d;
    logic [15:0] exmem_sd_q, exmem_sd_d;
    logic [1:0]  exmem_wr_q, exmem_wr_d;
    logic        exmem_rw_q, exmem_rw_d;
    logic        exmem_mtr_q, exmem_mtr_d;
    logic        exmem_mw_q, exmem_mw_d;

    logic        memwb_valid_q, memwb_valid_d;
    logic [15:0] memwb_alu_q, memwb_alu_d;
    logic [15:0] memwb_ld_q, memwb_ld_d;
    logic [1:0]  memwb_wr_q, memwb_wr_d;
    logic        memwb_rw_q, memwb_rw_d;
    logic        memwb_mtr_q, memwb_mtr_d;

    logic        fault_q, fault_d;
    logic [15:0] fault_addr_q, fault_addr_d;
    logic [15:0] retired_q, retired_d;

    logic [15:0] dmem [256];
    logic [15:0] dmem_rdata;
    logic        dmem_we;
    logic        misalign;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = exmem_alu_q[0] & (exmem_mw_q | exmem_mtr_q);
`else
    assign misalign = 1'b0;
`endif

    assign dmem_rdata = dmem[exmem_alu_q[8:1]];
    assign dmem_we    = exmem_mw_q & ~misalign;

    always_comb begin
        // A bubble keeps its data fields but carries no control bits.
        exmem_valid_d = ex_valid;
        exmem_alu_d   = ex_alu_out;
        exmem_sd_d    = ex_store_data;
        exmem_wr_d    = ex_wr;
        exmem_rw_d    = ex_valid & ex_regwrite;
        exmem_mtr_d   = ex_valid & ex_memtoreg;
        exmem_mw_d    = ex_valid & ex_memwrite;

        memwb_valid_d = exmem_valid_q;
        memwb_alu_d   = exmem_alu_q;
        memwb_ld_d    = dmem_rdata;
        memwb_wr_d    = exmem_wr_q;
        memwb_rw_d    = exmem_rw_q & ~misalign;
        memwb_mtr_d   = exmem_mtr_q;

        fault_d      = fault_q | misalign;
        fault_addr_d = (misalign && !fault_q) ? exmem_alu_q : fault_addr_q;
        retired_d    = retired_q + {15'd0, memwb_valid_q};
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exmem_valid_q <= 1'b0;
            exmem_alu_q   <= '0;
            exmem_sd_q    <= '0;
            exmem_wr_q    <= '0;
            exmem_rw_q    <= 1'b0;
            exmem_mtr_q   <= 1'b0;
            exmem_mw_q    <= 1'b0;
            memwb_valid_q <= 1'b0;
            memwb_alu_q   <= '0;
            memwb_ld_q    <= '0;
            memwb_wr_q    <= '0;
            memwb_rw_q    <= 1'b0;
            memwb_mtr_q   <= 1'b0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            retired_q     <= '0;
        end else begin
            exmem_valid_q <= exmem_valid_d;
            exmem_alu_q   <= exmem_alu_d;
            exmem_sd_q    <= exmem_sd_d;
            exmem_wr_q    <= exmem_wr_d;
            exmem_rw_q    <= exmem_rw_d;
            exmem_mtr_q   <= exmem_mtr_d;
            exmem_mw_q    <= exmem_mw_d;
            memwb_valid_q <= memwb_valid_d;
            memwb_alu_q   <= memwb_alu_d;
            memwb_ld_q    <= memwb_ld_d;
            memwb_wr_q    <= memwb_wr_d;
            memwb_rw_q    <= memwb_rw_d;
            memwb_mtr_q   <= memwb_mtr_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
            retired_q     <= retired_d;
        end
    end

    // Data memory is never reset; the store enable is already low while reset holds EX/MEM clear.
    always_ff @(negedge clock) begin
        if (dmem_we) begin
            dmem[exmem_alu_q[8:1]] <= exmem_sd_q;
        end
    end

    assign wb_wd          = memwb_mtr_q ? memwb_ld_q : memwb_alu_q;
    assign wb_wr          = memwb_wr_q;
    assign wb_regwrite    = memwb_rw_q & (memwb_wr_q != 2'd0);
    assign exmem_wr       = exmem_wr_q;
    assign exmem_regwrite = exmem_rw_q;
    assign exmem_alu_out  = exmem_alu_q;
    assign fault          = fault_q;
    assign fault_addr     = fault_addr_q;
    assign retired        = retired_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state updates on its negative edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ex_valid, input, 1 bit: the EX stage presents a real instruction this cycle.
REQ-004 SHALL have port ex_alu_out, input, 16 bits: ALU result, used as the byte address for LW/SW.
REQ-005 SHALL have port ex_store_data, input, 16 bits: rt operand for SW.
REQ-006 SHALL have port ex_wr, input, 2 bits: destination register number.
REQ-007 SHALL have ports ex_regwrite, ex_memtoreg and ex_memwrite, inputs, 1 bit each: control bits from the ID/EX register.
REQ-008 SHALL have port wb_wd, output, 16 bits: write-back data to the register file.
REQ-009 SHALL have port wb_wr, output, 2 bits: write-back register number.
REQ-010 SHALL have port wb_regwrite, output, 1 bit: register-file write enable.
REQ-011 SHALL have ports exmem_wr (2 bits), exmem_regwrite (1 bit) and exmem_alu_out (16 bits), outputs: EX/MEM contents, for a later forwarding unit.
REQ-012 SHALL have port fault, output, 1 bit: sticky misaligned-access flag.
REQ-013 SHALL have port fault_addr, output, 16 bits: address of the first faulting access.
REQ-014 SHALL have port retired, output, 16 bits: count of write-back-stage valid instructions.

Function
REQ-015 SHALL register all ex_* inputs into the EX/MEM register on each negedge clock; when ex_valid=0, the control bits captured SHALL be 0 (a nop).
REQ-016 SHALL contain a data memory of 256 x 16 bits, indexed by exmem address bits [8:1]; address bits [15:9] SHALL be ignored.
REQ-017 SHALL write exmem store data to the data memory at negedge clock when exmem_memwrite=1 and the access is not faulting.
REQ-018 SHALL read the data memory combinationally from the EX/MEM address and capture the read data into the MEM/WB register at the same negedge.
REQ-019 SHALL produce wb_wd = MEM/WB load data when memtoreg=1, otherwise the MEM/WB ALU result.
REQ-020 SHALL hold a result for 2 negedges from EX presentation to wb_* outputs, and SHALL accept one instruction per cycle with no stalls.
REQ-021 SHALL force wb_regwrite=0 when wb_wr=0, since $0 is hardwired.
REQ-022 SHALL make a load that follows a store to the same address, back to back, return the stored value.
REQ-023 SHALL increment retired by 1 each negedge on which MEM/WB holds a valid instruction, wrapping from 16'hFFFF to 0.

Reset
REQ-024 SHALL, while reset_n=0, immediately clear the EX/MEM and MEM/WB registers, all outputs, fault, fault_addr and retired to 0, independent of clock.
REQ-025 SHALL NOT clear the data memory on reset; its contents after power-up are undefined until written.
REQ-026 SHALL drop an instruction that is in flight when reset asserts, with no memory write and no register write.

Configuration
REQ-027 SHALL, when macro DMEM_MISALIGN_TRAP_EN is defined, treat an access with (memwrite or memtoreg)=1 and address bit 0=1 as faulting: the store SHALL be suppressed, wb_regwrite for the load SHALL be forced to 0, fault SHALL be set until reset, and fault_addr SHALL capture the first faulting address only.
REQ-028 SHALL, when DMEM_MISALIGN_TRAP_EN is undefined, ignore address bit 0, tie fault and fault_addr to 0, and never suppress accesses.

Verification
REQ-029 SHALL pass this scenario: ADD result 16'h0016 with wr=3 and regwrite=1 -> two negedges later wb_wd=16'h0016, wb_wr=3, wb_regwrite=1.
REQ-030 SHALL pass this scenario: SW with addr=16'h0004 and data=16'h00AB, immediately followed by LW with addr=16'h0004 and wr=2 -> the LW write-back gives wb_wd=16'h00AB, wb_wr=2.
REQ-031 SHALL pass this scenario: ADDI with wr=0 and regwrite=1 -> wb_regwrite=0, and retired still increments.
REQ-032 SHALL pass this scenario: with DMEM_MISALIGN_TRAP_EN defined, SW addr=16'h0005 then LW addr=16'h0007 -> memory word 2 is unchanged, the LW has wb_regwrite=0, fault=1, fault_addr=16'h0005.
REQ-033 SHALL pass this scenario: reset_n driven low mid-stream between clock edges -> all outputs go to 0 at once, and a SW that was in EX/MEM does not modify memory.
REQ-034 SHALL pass this scenario: retired preloaded to 16'hFFFF through 65535 valid instructions, then one more -> retired=0.
